// File: rtl/irq_pkg.sv
// Shared definitions for the memory-mapped interrupt controller:
// register word offsets inside the 8-word window and CTRL bit positions.
package irq_pkg;

  localparam logic [2:0] IRQ_OFS_PENDING = 3'd0;
  localparam logic [2:0] IRQ_OFS_ENABLE  = 3'd1;
  localparam logic [2:0] IRQ_OFS_TRIGGER = 3'd2;
  localparam logic [2:0] IRQ_OFS_SWSET   = 3'd3;
  localparam logic [2:0] IRQ_OFS_CTRL    = 3'd4;
  localparam logic [2:0] IRQ_OFS_CURRENT = 3'd5;

  localparam int IRQ_CTRL_GIE = 0;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer bank for asynchronous interrupt source lines.
// Used by irq_ctrl only when IRQ_CTRL_SYNC_EN is defined.
module irq_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: pending/enable/trigger registers,
// lowest-index priority request to the CPU. Define IRQ_CTRL_SYNC_EN for input sync.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          NSRC = 8,
  parameter logic [15:0] BASE = 16'hFF00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     address,
  input  logic [31:0]     data,
  input  logic            wren,
  output logic [31:0]     rdata,
  output logic            sel,
  input  logic [NSRC-1:0] src,
  output logic            IRQ,
  output logic [7:0]      IRQn
);

  logic [NSRC-1:0] src_c;
  logic [NSRC-1:0] hist_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] ena_q;
  logic [NSRC-1:0] trig_q;
  logic [NSRC-1:0] eff_pend;
  logic [NSRC-1:0] req;
  logic [NSRC-1:0] w1c, sws, hws;
  logic            gie_q;
  logic            irq_q;
  logic [7:0]      irqn_q, irqn_d;
  logic [2:0]      ofs;
  logic            wr;
  logic [31:0]     rd;
  logic            unused_data;

`ifdef IRQ_CTRL_SYNC_EN
  irq_sync #(.W(NSRC)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (src),
    .q_o   (src_c)
  );
`else
  assign src_c = src;
`endif

  assign sel = (address[15:3] == BASE[15:3]);
  assign ofs = address[2:0];
  assign wr  = wren & sel;
  assign unused_data = ^data;

  // Stored pending only moves for edge sources; level bits keep their value
  assign hws = src_c & ~hist_q & trig_q;
  assign w1c = (wr && ofs == IRQ_OFS_PENDING) ? data[NSRC-1:0] & trig_q : '0;
  assign sws = (wr && ofs == IRQ_OFS_SWSET) ? data[NSRC-1:0] & trig_q : '0;
  assign pend_d = (pend_q & ~w1c) | hws | sws;

  assign eff_pend = (pend_q & trig_q) | (src_c & ~trig_q);
  assign req = eff_pend & ena_q & {NSRC{gie_q}};

  always_comb begin
    irqn_d = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) irqn_d = 8'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      pend_q <= '0;
      ena_q  <= '0;
      trig_q <= '1;
      gie_q  <= 1'b0;
      irq_q  <= 1'b0;
      irqn_q <= '0;
    end else begin
      hist_q <= src_c;
      pend_q <= pend_d;
      if (wr && ofs == IRQ_OFS_ENABLE)  ena_q  <= data[NSRC-1:0];
      if (wr && ofs == IRQ_OFS_TRIGGER) trig_q <= data[NSRC-1:0];
      if (wr && ofs == IRQ_OFS_CTRL)    gie_q  <= data[IRQ_CTRL_GIE];
      irq_q  <= |req;
      irqn_q <= irqn_d;
    end
  end

  function automatic logic [31:0] zx(input logic [NSRC-1:0] v);
    zx = '0;
    zx[NSRC-1:0] = v;
  endfunction

  always_comb begin
    rd = '0;
    unique case (ofs)
      IRQ_OFS_PENDING: rd = zx(eff_pend);
      IRQ_OFS_ENABLE:  rd = zx(ena_q);
      IRQ_OFS_TRIGGER: rd = zx(trig_q);
      IRQ_OFS_CTRL:    rd[IRQ_CTRL_GIE] = gie_q;
      IRQ_OFS_CURRENT: rd = {irq_q, 23'b0, irqn_q};
      default:         rd = '0;
    endcase
  end

  assign rdata = sel ? rd : '0;
  assign IRQ   = irq_q;
  assign IRQn  = irqn_q;

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller that feeds the CPU's `IRQ`/`IRQn` inputs. It sits on the CPU data bus (`address`/`data`/`wren` in, read data out) beside the RAM, at a fixed 8-word window. It latches up to `NSRC` external interrupt sources as edge- or level-triggered and masks them per source and globally. The lowest-numbered pending, enabled source is presented to the CPU as a registered request plus its number. Software acknowledges a request by writing 1 to the corresponding pending bit.

## Interface
- `NSRC`, 8: number of interrupt sources, 1..32.
- `BASE`, 16'hFF00: word address of register window; must be 8-aligned.
- `clk` in 1: system clock, same clock as CPU and RAM.
- `reset` in 1: asynchronous, active-high reset.
- `address` in 16: CPU bus address.
- `data` in 32: CPU write data.
- `wren` in 1: CPU write enable.
- `rdata` out 32: read data, combinational.
- `sel` out 1: combinational window hit; external mux selects `rdata` over RAM `q` and gates RAM write enable.
- `src` in NSRC: raw interrupt source lines.
- `IRQ` out 1: registered interrupt request to CPU.
- `IRQn` out 8: registered number of the requesting source.

## Operation
- Register window covers `BASE`+0..7; `sel` = (`address[15:3]` == `BASE[15:3]`).
- Offset 0, PENDING: read returns the effective pending vector; write-1-to-clear, edge sources only.
- Offset 1, ENABLE: read/write mask.
- Offset 2, TRIGGER: read/write; bit 1 = edge, 0 = level.
- Offset 3, SWSET: write-only; 1 sets pending on edge sources; reads return 0.
- Offset 4, CTRL: read/write; bit0 = GIE (global enable); other bits read 0.
- Offset 5, CURRENT: read-only; {`IRQ`, 23'b0, `IRQn`}.
- Offsets 6–7 read 0; writes ignored.
- Bits at or above NSRC read 0 and ignore writes.
- Edge source: pending bit set on a rising edge of the conditioned input. Cleared only by W1C.
- Level source: effective pending equals the conditioned input level. W1C and SWSET have no effect on it.
- Switching a bit from edge to level leaves its stored pending bit in place but unused. Switching back re-exposes the stored bit.
- Request vector = effective pending & ENABLE & {NSRC{GIE}}.
- `IRQ` <= |request; `IRQn` <= index of the lowest set request bit, or 0 if none.
- Same-cycle conflicts on a bit:
  - Hardware edge set and W1C: set wins.
  - SWSET and W1C: set wins.
- Writes commit on the rising edge where `wren` && `sel`.
- Reads have no side effects.
- `rdata` = 0 when `sel` is low.
- Reset values:
  - PENDING 0, ENABLE 0, TRIGGER all 1, GIE 0.
  - Edge-detect history 0, synchronizer flops 0.
  - `IRQ` 0, `IRQn` 0.

## Timing
- Read: `rdata` is valid in the same cycle `address` is presented, so the CPU samples it on the following edge, exactly like RAM.
- Write at edge e: the new register value is visible at `rdata` after e. `IRQ`/`IRQn` reflect it after edge e+1.
- Source latency, with synchronizer (`src` high before edge k):
  - Pending set after edge k+2.
  - `IRQ` asserted after edge k+3.
- Source latency, without synchronizer: pending set after edge k, `IRQ` after edge k+1.
- Edge pulses must be high for at least one clock. Pulses shorter than that may be lost.
- Reset asserted mid-operation clears everything asynchronously. First edge detection happens after release, from history 0, so a source already high is detected as a rising edge.

## Configuration
- `IRQ_CTRL_SYNC_EN` defined: each `src` bit passes through a 2-flop synchronizer before edge detection and level use. Sources may be asynchronous.
- Undefined: `src` is used directly. Sources must be synchronous to `clk`, and latency shrinks by 2 cycles.

## Structure
- Shared package `irq_pkg` holds the register offsets (`IRQ_OFS_PENDING`..`IRQ_OFS_CURRENT`) and the CTRL bit index.
- Sub-module `irq_sync`: a parameterised-width 2-flop synchronizer with async reset. It is instantiated only under `IRQ_CTRL_SYNC_EN`.
- Top module holds the register file, edge detect, pending logic, priority encoder and read mux.

## Test plan
- Reset release, CTRL=1, ENABLE=8'h04, pulse `src[2]` for 1 cycle -> `IRQ`=1, `IRQn`=2 at the stated latency. PENDING reads 8'h04.
- With `src[5]` and `src[1]` pending and enabled -> `IRQn`=1. Write 8'h02 to PENDING -> `IRQn`=5 next cycle. Write 8'h20 -> `IRQ`=0.
- TRIGGER bit3=0, ENABLE=8'h08, hold `src[3]` high -> `IRQ`=1 with `IRQn`=3. W1C of bit 3 does not clear it. Drop `src[3]` -> `IRQ`=0.
- Edge on `src[0]` in the same cycle as a W1C of bit 0 -> PENDING bit 0 remains 1. SWSET 8'h80 -> PENDING bit 7 = 1.
- GIE=0 with pending & enabled nonzero -> `IRQ`=0 and CURRENT=0. Set GIE -> CURRENT reads 32'h8000_00nn.
- Assert `reset` asynchronously while `IRQ`=1 -> `IRQ`, PENDING, ENABLE and GIE clear immediately and TRIGGER reads all 1. Address outside the window -> `sel`=0, `rdata`=0, registers unchanged by `wren`.
